// File: rtl/cache_controller_pkg.sv
// Shared definitions for the data-cache controller.
//   WORD_OFFSET  : number of byte-offset bits dropped from a CPU address
//   ADDR_WIDTH   : default byte-address width
//   DATA_WIDTH   : default word width
//   ctrl_state_t : controller FSM encoding (also exported on the debug port)
package cache_ctrl_pkg;

    localparam int WORD_OFFSET = 2;
    localparam int ADDR_WIDTH  = 32;
    localparam int DATA_WIDTH  = 32;

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        COMPARE   = 3'd1,
        MEM_READ  = 3'd2,
        MEM_WRITE = 3'd3,
        FILL      = 3'd4,
        RESPOND   = 3'd5
    } ctrl_state_t;

endpackage

// File: rtl/cache_controller_if.sv
// Bus bundle between the cache controller and its environment
// (CPU memory stage, cache array, memory bus, statistics).
//   master modport : the controller side
//   slave modport  : CPU / cache array / memory side
//
// Handshakes:
//   CPU    - cpu_req is a request pulse/level sampled only while the
//            controller is idle (cpu_busy=0); completion is a single-cycle
//            cpu_ready pulse, with cpu_rdata valid in that same cycle.
//   Memory - mem_req (with mem_we/mem_addr/mem_wdata stable) is held until
//            the cycle in which mem_ack=1; mem_req drops the following cycle.
//            mem_ack while mem_req=0 has no effect.
//   Cache  - cache_hit/cache_rdata are combinational from cache_addr;
//            cache_we is a single-cycle write strobe.
interface cache_controller_if #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32,
    parameter int CNT_WIDTH  = 16
);
    logic                  cpu_req;
    logic                  cpu_we;
    logic [ADDR_WIDTH-1:0] cpu_addr;
    logic [DATA_WIDTH-1:0] cpu_wdata;
    logic [DATA_WIDTH-1:0] cpu_rdata;
    logic                  cpu_ready;
    logic                  cpu_busy;

    logic [ADDR_WIDTH-1:0] cache_addr;
    logic [DATA_WIDTH-1:0] cache_wdata;
    logic                  cache_we;
    logic [DATA_WIDTH-1:0] cache_rdata;
    logic                  cache_hit;

    logic                  mem_req;
    logic                  mem_we;
    logic [ADDR_WIDTH-1:0] mem_addr;
    logic [DATA_WIDTH-1:0] mem_wdata;
    logic [DATA_WIDTH-1:0] mem_rdata;
    logic                  mem_ack;

    logic [CNT_WIDTH-1:0]  hit_cnt;
    logic [CNT_WIDTH-1:0]  miss_cnt;

    modport master (
        input  cpu_req, cpu_we, cpu_addr, cpu_wdata,
        output cpu_rdata, cpu_ready, cpu_busy,
        output cache_addr, cache_wdata, cache_we,
        input  cache_rdata, cache_hit,
        output mem_req, mem_we, mem_addr, mem_wdata,
        input  mem_rdata, mem_ack,
        output hit_cnt, miss_cnt
    );

    modport slave (
        output cpu_req, cpu_we, cpu_addr, cpu_wdata,
        input  cpu_rdata, cpu_ready, cpu_busy,
        input  cache_addr, cache_wdata, cache_we,
        output cache_rdata, cache_hit,
        input  mem_req, mem_we, mem_addr, mem_wdata,
        output mem_rdata, mem_ack,
        input  hit_cnt, miss_cnt
    );

endinterface

// File: rtl/cache_controller_sat_counter.sv
// Saturating up-counter used for cache hit/miss statistics.
//   clk     : clock, rising edge
//   rst     : synchronous active-high clear
//   inc_i   : count enable, one increment per cycle while high
//   count_o : current count; sticks at all-ones
module sat_counter #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             inc_i,
    output logic [WIDTH-1:0] count_o
);

    logic [WIDTH-1:0] count_q;
    logic [WIDTH-1:0] count_d;

    always_comb begin
        count_d = count_q;
        if (inc_i && (count_q != {WIDTH{1'b1}})) begin
            count_d = count_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign count_o = count_q;

endmodule

// File: rtl/cache_controller.sv
// Controller for an 8-line direct-mapped, word-granular data cache.
// Loads hit in the cache or fetch from memory and fill the line; stores
// are write-through with write-allocate (memory write, then cache update).
//   clk     : clock, rising edge
//   rst     : synchronous active-high reset
//   bus     : cache_controller_if.master (CPU, cache array, memory, counters)
//   state_o : current FSM state, for observation
module cache_controller #(
    parameter int ADDR_WIDTH = cache_ctrl_pkg::ADDR_WIDTH,
    parameter int DATA_WIDTH = cache_ctrl_pkg::DATA_WIDTH,
    parameter int CNT_WIDTH  = 16
) (
    input  logic                        clk,
    input  logic                        rst,
    cache_controller_if.master          bus,
    output cache_ctrl_pkg::ctrl_state_t state_o
);

    import cache_ctrl_pkg::*;

    // Byte-offset bits are forced to zero when the address is latched, so
    // the cache and memory always see a word-aligned address.
    localparam logic [ADDR_WIDTH-1:0] LOW_MASK = ADDR_WIDTH'((1 << WORD_OFFSET) - 1);

    ctrl_state_t           state_q, state_d;
    logic [ADDR_WIDTH-1:0] addr_q,  addr_d;
    logic                  we_q,    we_d;
    logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
    logic [DATA_WIDTH-1:0] rdata_q, rdata_d;

    logic hit_inc;
    logic miss_inc;

    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        we_d    = we_q;
        wdata_d = wdata_q;
        rdata_d = rdata_q;
        case (state_q)
            IDLE: begin
                if (bus.cpu_req) begin
                    addr_d  = bus.cpu_addr & ~LOW_MASK;
                    we_d    = bus.cpu_we;
                    wdata_d = bus.cpu_wdata;
                    state_d = COMPARE;
                end
            end
            COMPARE: begin
                if (we_q) begin
                    state_d = MEM_WRITE;
                end else if (bus.cache_hit) begin
                    rdata_d = bus.cache_rdata;
                    state_d = RESPOND;
                end else begin
                    state_d = MEM_READ;
                end
            end
            MEM_READ: begin
                if (bus.mem_ack) begin
                    rdata_d = bus.mem_rdata;
                    state_d = FILL;
                end
            end
            MEM_WRITE: begin
                if (bus.mem_ack) begin
                    state_d = FILL;
                end
            end
            FILL:    state_d = RESPOND;
            RESPOND: state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            addr_q  <= '0;
            we_q    <= 1'b0;
            wdata_q <= '0;
            rdata_q <= '0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            we_q    <= we_d;
            wdata_q <= wdata_d;
            rdata_q <= rdata_d;
        end
    end

    // Statistics are only counted for loads, on the COMPARE cycle.
    assign hit_inc  = (state_q == COMPARE) && !we_q &&  bus.cache_hit;
    assign miss_inc = (state_q == COMPARE) && !we_q && !bus.cache_hit;

    sat_counter #(.WIDTH(CNT_WIDTH)) u_hit_cnt (
        .clk     (clk),
        .rst     (rst),
        .inc_i   (hit_inc),
        .count_o (bus.hit_cnt)
    );

    sat_counter #(.WIDTH(CNT_WIDTH)) u_miss_cnt (
        .clk     (clk),
        .rst     (rst),
        .inc_i   (miss_inc),
        .count_o (bus.miss_cnt)
    );

    // Strobes are decoded straight from the state register, so a reset
    // removes them in the very next cycle.
    assign bus.cpu_busy    = (state_q != IDLE);
    assign bus.cpu_ready   = (state_q == RESPOND);
    assign bus.cpu_rdata   = rdata_q;
    assign bus.cache_addr  = addr_q;
    assign bus.cache_we    = (state_q == FILL);
    // A fill after a store writes the store data; after a load, the word
    // fetched from memory (held in rdata_q).
    assign bus.cache_wdata = we_q ? wdata_q : rdata_q;
    assign bus.mem_req     = (state_q == MEM_READ) || (state_q == MEM_WRITE);
    assign bus.mem_we      = (state_q == MEM_WRITE);
    assign bus.mem_addr    = addr_q;
    assign bus.mem_wdata   = wdata_q;
    assign state_o         = state_q;

endmodule

// File: tb/tb_cache_controller.sv
module tb_cache_controller;

    import cache_ctrl_pkg::*;

    // A 4-bit statistics counter lets saturation be reached by real
    // traffic in a few dozen transactions instead of 65k.
    localparam int CW = 4;

    typedef struct {
        logic        we;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic        hit;
        logic [31:0] word;       // cache_rdata on a hit, mem_rdata on a miss
        int          wait_cyc;   // mem_req cycles before the one carrying mem_ack
        int          exp_lat;    // cycles from the sampling edge to cpu_ready
        int          exp_req;    // cycles with mem_req=1
        int          exp_cwe;    // cache_we pulses
        logic [31:0] exp_cwdata;
        int          exp_hit;
        int          exp_miss;
    } vec_t;

    logic clk;
    logic rst;
    ctrl_state_t state_dbg;

    cache_controller_if #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .CNT_WIDTH(CW)) bus ();

    cache_controller #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .CNT_WIDTH(CW)) dut (
        .clk     (clk),
        .rst     (rst),
        .bus     (bus),
        .state_o (state_dbg)
    );

    int checks   = 0;
    int failures = 0;
    logic [31:0] exp_q[$];
    vec_t vecs[6];

    // ---------------- clock / reset ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        repeat (20000) @(posedge clk);
        $display("FAIL watchdog: simulation did not finish, got timeout required completion");
        $fatal(1, "watchdog expired");
    end

    // ---------------- helpers ----------------
    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h required %h", name, act, exp);
        end
    endtask

    task automatic run_txn(input vec_t v, input int idx);
        int k;
        int req_cyc;
        int cwe_cnt;
        int lat;
        logic [31:0] cwdata;
        logic [31:0] exp_rd;
        logic done;
        logic mem_we_ok;
        logic addr_ok;
        logic wdata_ok;
        string tag;
        tag = $sformatf("vec%0d", idx);
        k = 0; req_cyc = 0; cwe_cnt = 0; lat = -1; cwdata = '0;
        done = 1'b0; mem_we_ok = 1'b1; addr_ok = 1'b1; wdata_ok = 1'b1;
        bus.cache_hit   = v.hit;
        bus.cache_rdata = v.hit ? v.word : 32'h0BAD_0BAD;
        bus.mem_rdata   = v.word;
        if (!v.we) exp_q.push_back(v.word);
        @(negedge clk);
        bus.cpu_req   = 1'b1;
        bus.cpu_we    = v.we;
        bus.cpu_addr  = v.addr;
        bus.cpu_wdata = v.wdata;
        @(posedge clk);
        #1 bus.cpu_req = 1'b0;
        while (!done && k < 40) begin
            @(negedge clk);
            k++;
            bus.mem_ack = 1'b0;
            if (bus.mem_req) begin
                req_cyc++;
                if (bus.mem_we !== v.we) mem_we_ok = 1'b0;
                if (bus.mem_addr !== v.addr) addr_ok = 1'b0;
                if (v.we && bus.mem_wdata !== v.wdata) wdata_ok = 1'b0;
                if (req_cyc == v.wait_cyc + 1) bus.mem_ack = 1'b1;
            end
            if (bus.cache_we) begin
                cwe_cnt++;
                cwdata = bus.cache_wdata;
                if (bus.cache_addr !== v.addr) addr_ok = 1'b0;
            end
            if (bus.cpu_ready) begin
                done = 1'b1;
                lat  = k;
                if (!v.we && exp_q.size() > 0) begin
                    exp_rd = exp_q.pop_front();
                    check({tag, "_cpu_rdata"}, bus.cpu_rdata, exp_rd);
                end
            end
        end
        bus.mem_ack = 1'b0;
        if (!done) exp_q.delete();
        check({tag, "_completed"}, 32'(done), 32'd1);
        check({tag, "_latency"}, 32'(lat), 32'(v.exp_lat));
        check({tag, "_mem_req_cycles"}, 32'(req_cyc), 32'(v.exp_req));
        check({tag, "_cache_we_pulses"}, 32'(cwe_cnt), 32'(v.exp_cwe));
        if (v.exp_cwe > 0) check({tag, "_cache_wdata"}, cwdata, v.exp_cwdata);
        check({tag, "_mem_we_ok"}, 32'(mem_we_ok), 32'd1);
        check({tag, "_addr_ok"}, 32'(addr_ok), 32'd1);
        if (v.we) check({tag, "_mem_wdata_ok"}, 32'(wdata_ok), 32'd1);
        check({tag, "_hit_cnt"}, 32'(bus.hit_cnt), 32'(v.exp_hit));
        check({tag, "_miss_cnt"}, 32'(bus.miss_cnt), 32'(v.exp_miss));
        @(negedge clk);
        check({tag, "_idle_after"}, 32'(bus.cpu_busy), 32'd0);
    endtask

    // ---------------- main sequence ----------------
    initial begin
        int n_ready;
        int last;
        int cyc;
        int first_ready;
        int gap_bad;
        int rd_bad;
        int req_seen;
        int bad_cnt;

        rst = 1'b1;
        bus.cpu_req = 1'b0; bus.cpu_we = 1'b0; bus.cpu_addr = '0; bus.cpu_wdata = '0;
        bus.cache_rdata = '0; bus.cache_hit = 1'b0;
        bus.mem_rdata = '0; bus.mem_ack = 1'b0;

        // Reset held for two cycles
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst_state", 32'(state_dbg), 32'(IDLE));
        check("rst_cpu_busy", 32'(bus.cpu_busy), 32'd0);
        check("rst_strobes", {28'd0, bus.cpu_ready, bus.cache_we, bus.mem_req, bus.mem_we}, 32'd0);
        check("rst_hit_cnt", 32'(bus.hit_cnt), 32'd0);
        check("rst_miss_cnt", 32'(bus.miss_cnt), 32'd0);
        check("rst_cpu_rdata", bus.cpu_rdata, 32'd0);
        check("rst_cache_addr", bus.cache_addr, 32'd0);
        rst = 1'b0;

        // Directed vectors: latency = COMPARE + (wait+1) MEM_* + FILL + RESPOND for misses/stores
        vecs[0] = '{we:1'b0, addr:32'h40,  wdata:32'h0,         hit:1'b0, word:32'hDEADBEEF, wait_cyc:3,
                    exp_lat:7, exp_req:4, exp_cwe:1, exp_cwdata:32'hDEADBEEF, exp_hit:0, exp_miss:1};
        vecs[1] = '{we:1'b0, addr:32'h40,  wdata:32'h0,         hit:1'b1, word:32'hDEADBEEF, wait_cyc:0,
                    exp_lat:2, exp_req:0, exp_cwe:0, exp_cwdata:32'h0,        exp_hit:1, exp_miss:1};
        vecs[2] = '{we:1'b1, addr:32'h44,  wdata:32'h12345678,  hit:1'b0, word:32'h0,        wait_cyc:0,
                    exp_lat:4, exp_req:1, exp_cwe:1, exp_cwdata:32'h12345678, exp_hit:1, exp_miss:1};
        vecs[3] = '{we:1'b0, addr:32'h80,  wdata:32'h0,         hit:1'b0, word:32'hA5A50001, wait_cyc:1,
                    exp_lat:5, exp_req:2, exp_cwe:1, exp_cwdata:32'hA5A50001, exp_hit:1, exp_miss:2};
        vecs[4] = '{we:1'b1, addr:32'h100, wdata:32'hCAFEF00D,  hit:1'b1, word:32'h0,        wait_cyc:2,
                    exp_lat:6, exp_req:3, exp_cwe:1, exp_cwdata:32'hCAFEF00D, exp_hit:1, exp_miss:2};
        vecs[5] = '{we:1'b0, addr:32'h44,  wdata:32'h0,         hit:1'b1, word:32'h12345678, wait_cyc:0,
                    exp_lat:2, exp_req:0, exp_cwe:0, exp_cwdata:32'h0,        exp_hit:2, exp_miss:2};

        for (int i = 0; i < 6; i++) begin
            run_txn(vecs[i], i);
        end

        // Stray mem_ack while idle must not move the FSM
        @(negedge clk);
        bus.mem_ack = 1'b1;
        @(negedge clk);
        bus.mem_ack = 1'b0;
        check("stray_ack_state", 32'(state_dbg), 32'(IDLE));
        check("stray_ack_busy", 32'(bus.cpu_busy), 32'd0);

        // Reset in MEM_READ before mem_ack
        bus.cache_hit = 1'b0;
        bus.mem_rdata = 32'h0BADF00D;
        @(negedge clk);
        bus.cpu_req = 1'b1; bus.cpu_we = 1'b0; bus.cpu_addr = 32'h200;
        @(posedge clk);
        #1 bus.cpu_req = 1'b0;
        @(negedge clk);   // COMPARE
        @(negedge clk);   // MEM_READ
        check("midrst_mem_req_before", 32'(bus.mem_req), 32'd1);
        rst = 1'b1;
        @(negedge clk);
        check("midrst_mem_req_after", 32'(bus.mem_req), 32'd0);
        check("midrst_state", 32'(state_dbg), 32'(IDLE));
        check("midrst_cnts", {16'(bus.hit_cnt), 16'(bus.miss_cnt)}, 32'd0);
        rst = 1'b0;
        bad_cnt = 0;
        for (int i = 0; i < 6; i++) begin
            if (i == 0) bus.mem_ack = 1'b1;
            @(negedge clk);
            bus.mem_ack = 1'b0;
            if (bus.cache_we || bus.cpu_ready || bus.mem_req) bad_cnt++;
        end
        check("midrst_no_activity", 32'(bad_cnt), 32'd0);

        // 34 back-to-back hits with cpu_req held: one accept per 3 cycles, saturation at 15
        bus.cache_hit = 1'b1;
        bus.cache_rdata = 32'h5A5A0F0F;
        @(negedge clk);
        bus.cpu_req = 1'b1; bus.cpu_we = 1'b0; bus.cpu_addr = 32'h40;
        n_ready = 0; last = -1; cyc = 0; first_ready = -1; gap_bad = 0; rd_bad = 0; req_seen = 0;
        while (n_ready < 34 && cyc < 200) begin
            @(negedge clk);
            cyc++;
            if (bus.mem_req) req_seen++;
            if (bus.cpu_ready) begin
                n_ready++;
                if (first_ready < 0) first_ready = cyc;
                if (last >= 0 && (cyc - last) != 3) gap_bad++;
                last = cyc;
                if (bus.cpu_rdata !== 32'h5A5A0F0F) rd_bad++;
                if (n_ready == 14) check("b2b_hit_cnt_14", 32'(bus.hit_cnt), 32'd14);
                if (n_ready == 15) check("b2b_hit_cnt_15", 32'(bus.hit_cnt), 32'd15);
            end
        end
        bus.cpu_req = 1'b0;
        check("b2b_ready_count", 32'(n_ready), 32'd34);
        check("b2b_first_latency", 32'(first_ready), 32'd2);
        check("b2b_spacing_errors", 32'(gap_bad), 32'd0);
        check("b2b_rdata_errors", 32'(rd_bad), 32'd0);
        check("b2b_mem_req_cycles", 32'(req_seen), 32'd0);
        check("b2b_hit_cnt_sat", 32'(bus.hit_cnt), 32'd15);
        check("b2b_miss_cnt", 32'(bus.miss_cnt), 32'd0);
        repeat (3) @(negedge clk);
        check("b2b_idle_end", 32'(state_dbg), 32'(IDLE));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
